// File: rtl/average_pkg.sv
// Shared definitions for the averaging sequencer: FSM state encoding and a
// width helper for counters that must represent 0..max_value.
package average_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CLEAR   = 3'd1,
    S_REQUEST = 3'd2,
    S_WAIT    = 3'd3,
    S_ADD     = 3'd4,
    S_SHOW    = 3'd5,
    S_DONE    = 3'd6
  } state_t;

  // Bits needed to hold every value in 0..max_value (clog2(max_value+1), min 1).
  function automatic int cnt_width(input int max_value);
    int w;
    w = 1;
    while ((32'd1 << w) <= max_value) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/timeout_counter.sv
// Wait-cycle counter: cleared by load, counts up on inc and sticks at the
// configured limit, flagging limit_reached while it sits there.
module timeout_counter
  import average_pkg::*;
#(
  parameter int timeout_cycles = 255,
  localparam int CntW = cnt_width(timeout_cycles)
) (
  input  logic clock,
  input  logic reset,
  input  logic load_i,
  input  logic inc_i,
  output logic limit_reached_o
);

  localparam logic [CntW-1:0] Limit = CntW'(timeout_cycles);

  logic [CntW-1:0] count_q;
  logic [CntW-1:0] count_d;

  // Next count: load wins, then a saturating increment.
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = '0;
    end else if (inc_i && (count_q != Limit)) begin
      count_d = count_q + CntW'(1);
    end else begin
      count_d = count_q;
    end
  end

  // Count register.
  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign limit_reached_o = (count_q == Limit);

endmodule

// File: rtl/average_sequencer.sv
// Moore sequencer for one averaging cycle: clear, request/add 2^samples_log2
// ADC samples, publish the mean; with continuous restart, abort and timeout.
module average_sequencer
  import average_pkg::*;
#(
  parameter int samples_log2   = 4,
  parameter int timeout_cycles = 255
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  continuous,
  input  logic                  abort,
  input  logic                  sample_valid,
  output logic                  sample_request,
  output logic                  clear,
  output logic                  add,
  output logic                  show,
  output logic                  busy,
  output logic                  done,
  output logic                  timeout_error,
  output logic [samples_log2:0] sample_count
);

  localparam int CntW = samples_log2 + 1;
  localparam logic [CntW-1:0] CntLast = CntW'((32'd1 << samples_log2) - 32'd1);

  state_t          state_q, state_d;
  logic [CntW-1:0] count_q, count_d;
  logic            error_q, error_d;
  logic            wait_load_s;
  logic            wait_inc_s;
  logic            wait_limit_s;

  timeout_counter #(
    .timeout_cycles(timeout_cycles)
  ) u_wait (
    .clock          (clock),
    .reset          (reset),
    .load_i         (wait_load_s),
    .inc_i          (wait_inc_s),
    .limit_reached_o(wait_limit_s)
  );

  // Next-state, sample count and sticky error; abort overrides everything but IDLE.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    error_d     = error_q;
    wait_load_s = 1'b0;
    wait_inc_s  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_CLEAR;
          error_d = 1'b0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CLEAR: begin
        state_d = S_REQUEST;
        count_d = '0;
      end
      S_REQUEST: begin
        state_d     = S_WAIT;
        wait_load_s = 1'b1;
      end
      S_WAIT: begin
        if (sample_valid) begin
          state_d = S_ADD;
        end else if (wait_limit_s) begin
          state_d = S_IDLE;
          error_d = 1'b1;
        end else begin
          wait_inc_s = 1'b1;
        end
      end
      S_ADD: begin
        count_d = count_q + CntW'(1);
        if (count_q == CntLast) begin
          state_d = S_SHOW;
        end else begin
          state_d = S_REQUEST;
        end
      end
      S_SHOW: begin
        state_d = S_DONE;
      end
      S_DONE: begin
        if (continuous) begin
          state_d = S_CLEAR;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (abort && (state_q != S_IDLE)) begin
      state_d     = S_IDLE;
      count_d     = count_q;
      error_d     = error_q;
      wait_load_s = 1'b0;
      wait_inc_s  = 1'b0;
    end else begin
      wait_load_s = wait_load_s;
    end
  end

  // State, count and error registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      count_q <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      error_q <= error_d;
    end
  end

  assign sample_request = (state_q == S_REQUEST);
  assign clear          = (state_q == S_CLEAR);
  assign add            = (state_q == S_ADD);
  assign show           = (state_q == S_SHOW);
  assign done           = (state_q == S_DONE);
  assign busy           = (state_q != S_IDLE);
  assign timeout_error  = error_q;
  assign sample_count   = count_q;

endmodule
